// File: rtl/asip_regfile_pkg.sv
// Shared types and constants for the vector register file and its scoreboard.
// Optional feature macro: VREGFILE_WB_BYPASS_EN (see vector_regfile_wb.sv).
package asip_regfile_pkg;

  localparam int VEC_SIZE     = 4;
  localparam int REG_SIZE     = 8;
  localparam int NUM_VREGS    = 16;
  localparam int IDX_W        = $clog2(NUM_VREGS);
  localparam int MAX_INFLIGHT = 3;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_t;
  typedef logic [IDX_W-1:0]                  reg_idx_t;
  typedef logic [1:0]                        cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'(MAX_INFLIGHT);

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight write counters, issue back-pressure, read stall and sticky error.
// With VREGFILE_WB_BYPASS_EN, a read matching the current writeback sees the post-write count.
module regfile_scoreboard
  import asip_regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_VREGS,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dest,
  output logic          issue_ready,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          rd_stall,
  output logic          sb_error
);

  cnt_t cnt_arr [NUM_REGS];
  cnt_t dest_cnt, wb_cnt, cnt_a, cnt_b;
  logic issue_fire;
  logic stall_a, stall_b;
  logic err_q, err_d;

  assign dest_cnt = cnt_arr[issue_dest];
  assign wb_cnt   = cnt_arr[wb_addr];
  assign cnt_a    = cnt_arr[rd_addr_a];
  assign cnt_b    = cnt_arr[rd_addr_b];

  // A full register can still accept an issue when a writeback frees a slot this cycle.
  assign issue_ready = (dest_cnt < CNT_MAX) ||
                       (wb_we && (wb_addr == issue_dest) && (dest_cnt != '0));
  assign issue_fire  = issue_valid && issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      cnt_t cnt_q, cnt_d;
      logic inc, dec;

      assign inc = issue_fire && (issue_dest == AW'(gi));
      assign dec = wb_we && (wb_addr == AW'(gi));

      always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
          cnt_d = cnt_q + 2'd1;
        end else if (dec && !inc) begin
          if (cnt_q != '0) cnt_d = cnt_q - 2'd1;
        end else if (inc && dec) begin
          // Underflowing writeback cancels nothing, so the new issue still counts.
          if (cnt_q == '0) cnt_d = 2'd1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign cnt_arr[gi] = cnt_q;
    end
  endgenerate

`ifdef VREGFILE_WB_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a   = wb_we && (wb_addr == rd_addr_a);
  assign hit_b   = wb_we && (wb_addr == rd_addr_b);
  assign stall_a = hit_a ? (cnt_a > 2'd1) : (cnt_a != '0);
  assign stall_b = hit_b ? (cnt_b > 2'd1) : (cnt_b != '0);
`else
  assign stall_a = (cnt_a != '0);
  assign stall_b = (cnt_b != '0);
`endif

  assign rd_stall = stall_a || stall_b;

  assign err_d = err_q || (wb_we && (wb_cnt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign sb_error = err_q;

endmodule

// File: rtl/vector_regfile_wb.sv
// Vector register file fed by writeback: two combinational read ports, one lane-masked write port.
// Define VREGFILE_WB_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module vector_regfile_wb
  import asip_regfile_pkg::*;
#(
  parameter  int vecSize      = VEC_SIZE,
  parameter  int registerSize = REG_SIZE,
  parameter  int NUM_REGS     = NUM_VREGS,
  localparam int AW           = $clog2(NUM_REGS),
  localparam int DW           = vecSize * registerSize
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      rd_addr_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [DW-1:0]      rd_data_a,
  output logic [DW-1:0]      rd_data_b,
  output logic               rd_stall,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_dest,
  output logic               issue_ready,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_addr,
  input  logic [vecSize-1:0] wb_lane_mask,
  input  logic [DW-1:0]      wb_data,
  output logic               sb_error
);

  logic [vecSize-1:0][registerSize-1:0] wb_vec;
  logic [vecSize-1:0][registerSize-1:0] mem [NUM_REGS];

  assign wb_vec = wb_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [vecSize-1:0][registerSize-1:0] row_q, row_d;

      always_comb begin
        row_d = row_q;
        if (wb_we && (wb_addr == AW'(gi))) begin
          for (int l = 0; l < vecSize; l++) begin
            if (wb_lane_mask[l]) row_d[l] = wb_vec[l];
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) row_q <= '0;
        else       row_q <= row_d;
      end

      assign mem[gi] = row_q;
    end
  endgenerate

`ifdef VREGFILE_WB_BYPASS_EN
  logic [vecSize-1:0][registerSize-1:0] wb_row, merged;

  assign wb_row = mem[wb_addr];

  generate
    for (gi = 0; gi < vecSize; gi++) begin : g_merge
      assign merged[gi] = wb_lane_mask[gi] ? wb_vec[gi] : wb_row[gi];
    end
  endgenerate

  // Forwarding mirrors exactly what the array will hold after this edge.
  assign rd_data_a = (wb_we && (wb_addr == rd_addr_a)) ? merged : mem[rd_addr_a];
  assign rd_data_b = (wb_we && (wb_addr == rd_addr_b)) ? merged : mem[rd_addr_b];
`else
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
`endif

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_ready (issue_ready),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_stall    (rd_stall),
    .sb_error    (sb_error)
  );

endmodule

// File: tb/tb_vector_regfile_wb.sv
// Scoreboard bench for vector_regfile_wb: stimulus queues expected outputs, a monitor checks them.
// Expected values follow VREGFILE_WB_BYPASS_EN when it is defined.
module tb_vector_regfile_wb;

  localparam bit BYP =
`ifdef VREGFILE_WB_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_stall;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic        issue_ready;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [3:0]  wb_lane_mask;
  logic [31:0] wb_data;
  logic        sb_error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  vector_regfile_wb dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .rd_stall     (rd_stall),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .issue_ready  (issue_ready),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_lane_mask (wb_lane_mask),
    .wb_data      (wb_data),
    .sb_error     (sb_error)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic stall, input logic ready, input logic err);
    exp_t e;
    e.name = name; e.a = a; e.b = b; e.stall = stall; e.ready = ready; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [3:0] addr, input logic [3:0] mask, input logic [31:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_lane_mask = mask; wb_data = data;
  endtask

  // Monitor: outputs are combinational, so every queued expectation is judged mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_data_a !== e.a || rd_data_b !== e.b || rd_stall !== e.stall ||
            issue_ready !== e.ready || sb_error !== e.err) begin
          bad++;
          $display("FAIL %s: got a=%08h b=%08h stall=%b ready=%b err=%b, want a=%08h b=%08h stall=%b ready=%b err=%b",
                   e.name, rd_data_a, rd_data_b, rd_stall, issue_ready, sb_error,
                   e.a, e.b, e.stall, e.ready, e.err);
        end else begin
          $display("ok %s: a=%08h b=%08h stall=%b ready=%b err=%b",
                   e.name, rd_data_a, rd_data_b, rd_stall, issue_ready, sb_error);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    rd_addr_a = 4'd0; rd_addr_b = 4'd15;
    issue_valid = 1'b0; issue_dest = 4'd0;
    wb_we = 1'b0; wb_addr = 4'd0; wb_lane_mask = 4'h0; wb_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_r0_r15", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Full-mask write releases the stall at the write edge
    cyc(); rd_addr_a = 4'd4; rd_addr_b = 4'd0; issue_valid = 1'b1; issue_dest = 4'd4;
    chk("t2_issue", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(); issue_valid = 1'b0; wb(4'd4, 4'hF, 32'hDEADBEEF);
    chk("t2_wb", BYP ? 32'hDEADBEEF : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, 1'b0);
    cyc(); wb_we = 1'b0;
    chk("t2_after", 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0);

    // Lanes 0 and 2 replaced: DE|FE|BE|BE
    cyc(); issue_valid = 1'b1;
    chk("t3_issue", 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(); wb(4'd4, 4'b0101, 32'hCAFEBABE);
    chk("t3_merge", BYP ? 32'hDEFEBEBE : 32'hDEADBEEF, 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, 1'b0);
    cyc(); issue_valid = 1'b0; wb(4'd4, 4'h0, 32'hFFFFFFFF);
    chk("t3_mask0", 32'hDEFEBEBE, 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, 1'b0);
    cyc(); wb_we = 1'b0;
    chk("t3_after", 32'hDEFEBEBE, 32'h0, 1'b0, 1'b1, 1'b0);

    // Fill r7 to the in-flight limit
    cyc(); rd_addr_a = 4'd7; issue_valid = 1'b1; issue_dest = 4'd7;
    chk("t4_iss1", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(); chk("t4_iss2", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(); chk("t4_iss3", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(); chk("t4_full", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(); wb(4'd7, 4'hF, 32'h0A0B0C0D);
    chk("t4_wb_frees", BYP ? 32'h0A0B0C0D : 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(); issue_valid = 1'b0; wb_we = 1'b0;
    chk("t4_still3", 32'h0A0B0C0D, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(); wb(4'd7, 4'h0, 32'h0);
    chk("t4_drain3", 32'h0A0B0C0D, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(); chk("t4_drain2", 32'h0A0B0C0D, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(); chk("t4_drain1", 32'h0A0B0C0D, 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, 1'b0);
    cyc(); wb_we = 1'b0;
    chk("t4_empty", 32'h0A0B0C0D, 32'h0, 1'b0, 1'b1, 1'b0);

    // Writeback with nothing in flight: data lands, error sticks
    cyc(); rd_addr_a = 4'd2; wb(4'd2, 4'hF, 32'h11223344);
    chk("t5_wb_cnt0", BYP ? 32'h11223344 : 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(); wb_we = 1'b0;
    chk("t5_err_set", 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(); chk("t5_err_sticky", 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b1);

    // Same-cycle visibility of a writeback on the read ports
    cyc(); rd_addr_a = 4'd9; rd_addr_b = 4'd4; issue_valid = 1'b1; issue_dest = 4'd9;
    chk("t6_issue", 32'h0, 32'hDEFEBEBE, 1'b0, 1'b1, 1'b1);
    cyc(); issue_valid = 1'b0; wb(4'd9, 4'hF, 32'h12345678);
    chk("t6_wb_a", BYP ? 32'h12345678 : 32'h0, 32'hDEFEBEBE, BYP ? 1'b0 : 1'b1, 1'b1, 1'b1);
    cyc(); wb_we = 1'b0;
    chk("t6_after", 32'h12345678, 32'hDEFEBEBE, 1'b0, 1'b1, 1'b1);
    cyc(); rd_addr_b = 4'd9; issue_valid = 1'b1;
    chk("t6_portb", 32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset with r9 in flight
    cyc(); issue_valid = 1'b0; reset = 1'b1;
    chk("mid_reset", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(); reset = 1'b0;
    chk("post_reset", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    cyc();
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
